shwr_area_buffer: RTL and testbench
===================================

// Module: shwr_area_buffer
// PURPOSE
//  Reader side of the shower integral calculator. Tracks TRIGGERED and latches the
//  final INTEGRAL/PEAK/SATURATED once the area window has closed, plus BASELINE at
//  trigger start. Pushes each result as one event entry into a small FWFT FIFO that
//  the processor drains through BUF_RD. Sits between shwr_integral and the AXI regs.
// PARAMETERS
//  DEPTH        4                 FIFO entries; power of 2, 2..16
//  AREA_BINS    `SHWR_AREA_BINS   area window length of the upstream integrator
//  CAPTURE_LAT  2                 cycles after AREA_BINS until upstream outputs are final
// PORTS
//  CLK120         in   1   120 MHz clock
//  RESET          in   1   synchronous, active-high reset
//  TRIGGERED      in   1   same trigger signal that drives the upstream integrator
//  INTEGRAL       in   `SHWR_AREA_WIDTH                     upstream integral
//  PEAK           in   `ADC_WIDTH                           upstream peak
//  BASELINE       in   `ADC_WIDTH+`SHWR_BASELINE_EXTRA_BITS upstream baseline
//  SATURATED      in   1   upstream saturation flag
//  BUF_RD         in   1   pop head entry (1-cycle strobe)
//  BUF_CLR        in   1   flush FIFO and clear OVERFLOW
//  BUF_INTEGRAL   out  `SHWR_AREA_WIDTH                     head entry integral
//  BUF_PEAK       out  `ADC_WIDTH                           head entry peak
//  BUF_BASELINE   out  `ADC_WIDTH+`SHWR_BASELINE_EXTRA_BITS head entry baseline
//  BUF_SATURATED  out  1   head entry saturation flag
//  BUF_SHORT      out  1   head entry: trigger ended before window closed
//  BUF_TIME       out  32  head entry timestamp (see CONFIGURATION)
//  BUF_VALID      out  1   FIFO not empty; BUF_* fields are valid
//  BUF_COUNT      out  clog2(DEPTH)+1   entries held
//  OVERFLOW       out  1   sticky: an entry was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM IDLE, window counter 0. Reset mid-event
//    discards the event; no entry is written.
//  - TRIG_D = TRIGGERED registered once; rise = TRIGGERED & !TRIG_D; fall = !TRIGGERED & TRIG_D.
//  - FSM:
//    IDLE   -> ACTIVE on rise. Latch BASELINE (frozen value from before trigger); CNT <= 0.
//    ACTIVE: CNT increments each cycle. At CNT == AREA_BINS+CAPTURE_LAT, write
//            {INTEGRAL,PEAK,BASELINE latch,SATURATED,SHORT=0} and go to DONE.
//            On fall before that, write {INTEGRAL,PEAK,...,SHORT=1} using the input
//            values of that same cycle (upstream still holds them) -> IDLE.
//    DONE   -> IDLE on fall; no write. A rise is only accepted from IDLE.
//  - CNT is 12 bits and saturates; it never wraps.
//  - FIFO: first-word fall-through. BUF_* show the head entry while BUF_VALID=1.
//    BUF_RD pops it and the next entry appears the following cycle.
//  - BUF_RD while empty: ignored. Write while full and no BUF_RD: entry dropped,
//    OVERFLOW <= 1. Write + BUF_RD in the same cycle: both performed, including
//    when full; BUF_COUNT is unchanged.
//  - BUF_CLR has priority over write and read: FIFO empty, OVERFLOW 0, BUF_VALID 0
//    next cycle. A write in the same cycle is discarded. The FSM is not affected.
//  - BUF_* fields hold their last value when empty. Only BUF_VALID qualifies them.
//  - Pointers wrap modulo DEPTH. BUF_COUNT ranges 0..DEPTH.
// CONFIGURATION
//  SHWR_AREA_BUF_TIMESTAMP_EN defined: a free-running 32-bit counter, cleared by
//    RESET, incrementing each CLK120 and wrapping. Its value at rise is latched and
//    stored in the entry as BUF_TIME.
//  Not defined: no counter or storage is built and BUF_TIME is tied to 0.
// TESTING
//  1 Rise, TRIGGERED held 40 cycles, INTEGRAL=1234 final at CNT=AREA_BINS+2, BASELINE=1000
//    -> one entry: 1234/PEAK/1000/SHORT=0; BUF_VALID=1, BUF_COUNT=1.
//  2 TRIGGERED high 5 cycles with INTEGRAL=77 on the fall cycle -> entry INTEGRAL=77,
//    SHORT=1; the FSM returns to IDLE.
//  3 Six events with DEPTH=4 and no reads -> BUF_COUNT=4, OVERFLOW=1, head is event 1;
//    4 pops return events 1-4 in order.
//  4 FIFO full, capture and BUF_RD in the same cycle -> BUF_COUNT stays 4, OVERFLOW stays 0,
//    the new entry is last.
//  5 BUF_CLR coincident with a capture -> BUF_COUNT=0, BUF_VALID=0, OVERFLOW=0; the next
//    event is stored normally.
//  6 RESET pulsed at CNT=10 -> no entry; with TIMESTAMP_EN, a rise 100 cycles after reset
//    release stores BUF_TIME=100 (+-1 per the rise-register stage); without it, BUF_TIME=0.

Source files
------------

// File: rtl/shwr_area_buffer.sv
// Shower area result buffer: latches one result per trigger into a small FWFT FIFO.
// Define SHWR_AREA_BUF_TIMESTAMP_EN to store a 32-bit rise timestamp per entry.
`ifndef SHWR_AREA_BINS
`define SHWR_AREA_BINS 20
`endif
`ifndef SHWR_AREA_WIDTH
`define SHWR_AREA_WIDTH 19
`endif
`ifndef ADC_WIDTH
`define ADC_WIDTH 12
`endif
`ifndef SHWR_BASELINE_EXTRA_BITS
`define SHWR_BASELINE_EXTRA_BITS 2
`endif

module shwr_area_buffer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AREA_BINS   = `SHWR_AREA_BINS,
  parameter int unsigned CAPTURE_LAT = 2
) (
  input  logic                                             CLK120,
  input  logic                                             RESET,
  input  logic                                             TRIGGERED,
  input  logic [`SHWR_AREA_WIDTH-1:0]                      INTEGRAL,
  input  logic [`ADC_WIDTH-1:0]                            PEAK,
  input  logic [`ADC_WIDTH+`SHWR_BASELINE_EXTRA_BITS-1:0]  BASELINE,
  input  logic                                             SATURATED,
  input  logic                                             BUF_RD,
  input  logic                                             BUF_CLR,
  output logic [`SHWR_AREA_WIDTH-1:0]                      BUF_INTEGRAL,
  output logic [`ADC_WIDTH-1:0]                            BUF_PEAK,
  output logic [`ADC_WIDTH+`SHWR_BASELINE_EXTRA_BITS-1:0]  BUF_BASELINE,
  output logic                                             BUF_SATURATED,
  output logic                                             BUF_SHORT,
  output logic [31:0]                                      BUF_TIME,
  output logic                                             BUF_VALID,
  output logic [$clog2(DEPTH):0]                           BUF_COUNT,
  output logic                                             OVERFLOW
);
  localparam int unsigned IW = `SHWR_AREA_WIDTH;
  localparam int unsigned PW = `ADC_WIDTH;
  localparam int unsigned BW = `ADC_WIDTH + `SHWR_BASELINE_EXTRA_BITS;
  localparam int unsigned EW = IW + PW + BW + 2;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [11:0] CntTarget = 12'(AREA_BINS + CAPTURE_LAT);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic          trig_q;
  logic          rise, fall;
  logic [1:0]    state_q, state_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [BW-1:0] base_q, base_d;
  logic          cap_wr, cap_short;
  logic [EW-1:0] wr_entry;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [EW-1:0] head_q, head_d;
  logic          rd_en, wr_en, drop, head_new;

  assign rise = TRIGGERED & ~trig_q;
  assign fall = ~TRIGGERED & trig_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    cap_wr    = 1'b0;
    cap_short = 1'b0;
    case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StActive;
          cnt_d   = '0;
          base_d  = BASELINE;
        end
      end
      StActive: begin
        if (cnt_q != '1) cnt_d = cnt_q + 12'd1;
        // A fall on the closing cycle still counts as a complete window.
        if (cnt_q == CntTarget) begin
          cap_wr  = 1'b1;
          state_d = fall ? StIdle : StDone;
        end else if (fall) begin
          cap_wr    = 1'b1;
          cap_short = 1'b1;
          state_d   = StIdle;
        end
      end
      StDone: begin
        if (fall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign wr_entry = {INTEGRAL, PEAK, base_q, SATURATED, cap_short};

  assign rd_en    = BUF_RD & (count_q != '0) & ~BUF_CLR;
  assign wr_en    = cap_wr & ~BUF_CLR & ((count_q != CW'(DEPTH)) | rd_en);
  assign drop     = cap_wr & ~BUF_CLR & (count_q == CW'(DEPTH)) & ~rd_en;
  // Entry being written lands directly at the new head (empty, or last entry popped).
  assign head_new = wr_en & (wr_ptr_q == rd_ptr_d);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (BUF_CLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (wr_en && !rd_en) begin
        count_d = count_q + CW'(1);
      end else if (!wr_en && rd_en) begin
        count_d = count_q - CW'(1);
      end
      if (drop) ovf_d = 1'b1;
    end
  end

  always_comb begin
    head_d = head_q;
    if (count_d != '0) head_d = head_new ? wr_entry : mem[rd_ptr_d];
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      trig_q   <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      base_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      trig_q   <= TRIGGERED;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge CLK120) begin
    if (wr_en) mem[wr_ptr_q] <= wr_entry;
  end

  assign {BUF_INTEGRAL, BUF_PEAK, BUF_BASELINE, BUF_SATURATED, BUF_SHORT} = head_q;
  assign BUF_VALID = (count_q != '0);
  assign BUF_COUNT = count_q;
  assign OVERFLOW  = ovf_q;

`ifdef SHWR_AREA_BUF_TIMESTAMP_EN
  logic [31:0] ts_q, ts_lat_q, head_time_q, head_time_d;
  logic [31:0] time_mem [DEPTH];

  always_comb begin
    head_time_d = head_time_q;
    if (count_d != '0) head_time_d = head_new ? ts_lat_q : time_mem[rd_ptr_d];
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      ts_q        <= '0;
      ts_lat_q    <= '0;
      head_time_q <= '0;
    end else begin
      ts_q        <= ts_q + 32'd1;
      if (state_q == StIdle && rise) ts_lat_q <= ts_q;
      head_time_q <= head_time_d;
    end
  end

  always_ff @(posedge CLK120) begin
    if (wr_en) time_mem[wr_ptr_q] <= ts_lat_q;
  end

  assign BUF_TIME = head_time_q;
`else
  assign BUF_TIME = '0;
`endif

endmodule

// File: tb/tb_shwr_area_buffer.sv
// Self-checking bench for shwr_area_buffer: random event data against a queue-based model.
`timescale 1ns/1ps
`ifndef SHWR_AREA_BINS
`define SHWR_AREA_BINS 20
`endif
`ifndef SHWR_AREA_WIDTH
`define SHWR_AREA_WIDTH 19
`endif
`ifndef ADC_WIDTH
`define ADC_WIDTH 12
`endif
`ifndef SHWR_BASELINE_EXTRA_BITS
`define SHWR_BASELINE_EXTRA_BITS 2
`endif

module tb_shwr_area_buffer;
  localparam int DEPTH = 4;
  localparam int T     = `SHWR_AREA_BINS + 2;
  localparam int IW    = `SHWR_AREA_WIDTH;
  localparam int PW    = `ADC_WIDTH;
  localparam int BW    = `ADC_WIDTH + `SHWR_BASELINE_EXTRA_BITS;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK120 = 1'b0;
  logic          RESET = 1'b1;
  logic          TRIGGERED = 1'b0;
  logic [IW-1:0] INTEGRAL = '0;
  logic [PW-1:0] PEAK = '0;
  logic [BW-1:0] BASELINE = '0;
  logic          SATURATED = 1'b0;
  logic          BUF_RD = 1'b0;
  logic          BUF_CLR = 1'b0;
  logic [IW-1:0] BUF_INTEGRAL;
  logic [PW-1:0] BUF_PEAK;
  logic [BW-1:0] BUF_BASELINE;
  logic          BUF_SATURATED, BUF_SHORT, BUF_VALID, OVERFLOW;
  logic [31:0]   BUF_TIME;
  logic [CW-1:0] BUF_COUNT;

  always #4 CLK120 = ~CLK120;

  shwr_area_buffer #(.DEPTH(DEPTH)) dut (
    .CLK120(CLK120), .RESET(RESET), .TRIGGERED(TRIGGERED), .INTEGRAL(INTEGRAL),
    .PEAK(PEAK), .BASELINE(BASELINE), .SATURATED(SATURATED), .BUF_RD(BUF_RD),
    .BUF_CLR(BUF_CLR), .BUF_INTEGRAL(BUF_INTEGRAL), .BUF_PEAK(BUF_PEAK),
    .BUF_BASELINE(BUF_BASELINE), .BUF_SATURATED(BUF_SATURATED), .BUF_SHORT(BUF_SHORT),
    .BUF_TIME(BUF_TIME), .BUF_VALID(BUF_VALID), .BUF_COUNT(BUF_COUNT), .OVERFLOW(OVERFLOW)
  );

  typedef struct {
    logic [IW-1:0] integ;
    logic [PW-1:0] peak;
    logic [BW-1:0] base;
    logic          sat;
    logic          shrt;
    logic [31:0]   tim;
  } ent_t;

  ent_t        mq[$];
  ent_t        ev_log[$];
  bit          m_ovf = 1'b0;
  bit          m_wr = 1'b0;
  ent_t        m_entry;
  logic [31:0] ts_m = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic ent_t dut_head();
    ent_t e;
    e = '{BUF_INTEGRAL, BUF_PEAK, BUF_BASELINE, BUF_SATURATED, BUF_SHORT, BUF_TIME};
    return e;
  endfunction

  function automatic bit ent_eq(ent_t a, ent_t b);
    return (a.integ === b.integ) && (a.peak === b.peak) && (a.base === b.base) &&
           (a.sat === b.sat) && (a.shrt === b.shrt) && (a.tim === b.tim);
  endfunction

  function automatic string ent_str(ent_t e);
    return $sformatf("{int=%0h pk=%0h bl=%0h sat=%0b short=%0b t=%0d}",
                     e.integ, e.peak, e.base, e.sat, e.shrt, e.tim);
  endfunction

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic tick();
    if (RESET) begin
      mq.delete();
      m_ovf = 1'b0;
      ts_m  = '0;
    end else begin
      ts_m = ts_m + 32'd1;
      if (BUF_CLR) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        if (BUF_RD && mq.size() > 0) void'(mq.pop_front());
        if (m_wr) begin
          ev_log.push_back(m_entry);
          if (mq.size() < DEPTH) mq.push_back(m_entry);
          else m_ovf = 1'b1;
        end
      end
    end
    m_wr = 1'b0;
    @(posedge CLK120);
    #1;
  endtask

  // Trigger high for len cycles then low for gap cycles; the entry is captured
  // after the full window, or on the fall cycle when the trigger is shorter.
  task automatic run_event(input int len, input int gap, input bit rd_at_wr,
                           input bit clr_at_wr, input bit rnd_rd,
                           input int fix_int, input int fix_base);
    int          wr_off;
    bit          shrt;
    logic [BW-1:0] base_lat;
    logic [31:0] rise_ts;
    shrt   = (len <= T);
    wr_off = shrt ? len : T + 1;
    base_lat = '0;
    rise_ts  = '0;
    for (int o = 0; o < len + gap; o++) begin
      TRIGGERED = (o < len);
      INTEGRAL  = (fix_int >= 0) ? IW'(fix_int) : IW'($urandom);
      PEAK      = PW'($urandom);
      SATURATED = 1'($urandom);
      BASELINE  = (o == 0 && fix_base >= 0) ? BW'(fix_base) : BW'($urandom);
      if (o == 0) begin
        base_lat = BASELINE;
        rise_ts  = ts_m;
      end
      BUF_RD  = rnd_rd ? ($urandom_range(0, 3) == 0) : (rd_at_wr && o == wr_off);
      BUF_CLR = clr_at_wr && (o == wr_off);
      if (o == wr_off) begin
        m_wr = 1'b1;
`ifdef SHWR_AREA_BUF_TIMESTAMP_EN
        m_entry = '{INTEGRAL, PEAK, base_lat, SATURATED, shrt, rise_ts};
`else
        m_entry = '{INTEGRAL, PEAK, base_lat, SATURATED, shrt, 32'd0};
`endif
      end
      tick();
      if (rnd_rd) begin
        n_cmp++;
        if (BUF_COUNT !== CW'(mq.size()) || BUF_VALID !== (mq.size() != 0) ||
            OVERFLOW !== m_ovf) begin
          n_bad++;
          $display("FAIL rnd_status t=%0t: count=%0d valid=%0b ovf=%0b, want %0d %0b %0b",
                   $time, BUF_COUNT, BUF_VALID, OVERFLOW, mq.size(), mq.size() != 0, m_ovf);
        end
        if (mq.size() != 0) begin
          n_cmp++;
          if (!ent_eq(dut_head(), mq[0])) begin
            n_bad++;
            $display("FAIL rnd_head t=%0t: got %s want %s", $time, ent_str(dut_head()),
                     ent_str(mq[0]));
          end
        end
      end
    end
    BUF_RD  = 1'b0;
    BUF_CLR = 1'b0;
  endtask

  task automatic do_clear();
    BUF_CLR = 1'b1;
    tick();
    BUF_CLR = 1'b0;
  endtask

  task automatic test_reset();
    ent_t zero;
    zero = '{'0, '0, '0, 1'b0, 1'b0, 32'd0};
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    n_cmp++;
    if (BUF_COUNT !== '0 || BUF_VALID !== 1'b0 || OVERFLOW !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_status: count=%0d valid=%0b ovf=%0b, want 0 0 0",
               BUF_COUNT, BUF_VALID, OVERFLOW);
    end
    n_cmp++;
    if (!ent_eq(dut_head(), zero)) begin
      n_bad++;
      $display("FAIL reset_fields: got %s want all zero", ent_str(dut_head()));
    end
  endtask

  task automatic test_full_window();
    run_event(40, 3, 1'b0, 1'b0, 1'b0, 1234, 1000);
    n_cmp++;
    if (BUF_COUNT !== CW'(1) || BUF_VALID !== 1'b1) begin
      n_bad++;
      $display("FAIL full_status: count=%0d valid=%0b, want 1 1", BUF_COUNT, BUF_VALID);
    end
    n_cmp++;
    if (BUF_INTEGRAL !== IW'(1234) || BUF_BASELINE !== BW'(1000) || BUF_SHORT !== 1'b0) begin
      n_bad++;
      $display("FAIL full_fields: int=%0d bl=%0d short=%0b, want 1234 1000 0",
               BUF_INTEGRAL, BUF_BASELINE, BUF_SHORT);
    end
    n_cmp++;
    if (!ent_eq(dut_head(), mq[0])) begin
      n_bad++;
      $display("FAIL full_head: got %s want %s", ent_str(dut_head()), ent_str(mq[0]));
    end
    BUF_RD = 1'b1;
    tick();
    BUF_RD = 1'b0;
    n_cmp++;
    if (BUF_VALID !== 1'b0 || BUF_COUNT !== '0) begin
      n_bad++;
      $display("FAIL full_pop: valid=%0b count=%0d, want 0 0", BUF_VALID, BUF_COUNT);
    end
  endtask

  task automatic test_short();
    run_event(5, 1, 1'b0, 1'b0, 1'b0, 77, -1);
    n_cmp++;
    if (BUF_COUNT !== CW'(1) || BUF_INTEGRAL !== IW'(77) || BUF_SHORT !== 1'b1) begin
      n_bad++;
      $display("FAIL short_entry: count=%0d int=%0d short=%0b, want 1 77 1",
               BUF_COUNT, BUF_INTEGRAL, BUF_SHORT);
    end
    n_cmp++;
    if (!ent_eq(dut_head(), mq[0])) begin
      n_bad++;
      $display("FAIL short_head: got %s want %s", ent_str(dut_head()), ent_str(mq[0]));
    end
    // A second trigger right away is only captured if the FSM went back to idle.
    run_event(3, 2, 1'b0, 1'b0, 1'b0, -1, -1);
    n_cmp++;
    if (BUF_COUNT !== CW'(2)) begin
      n_bad++;
      $display("FAIL short_rearm: count=%0d, want 2", BUF_COUNT);
    end
    do_clear();
  endtask

  task automatic test_overflow();
    int b;
    b = ev_log.size();
    for (int i = 0; i < 6; i++) run_event(30, 2, 1'b0, 1'b0, 1'b0, -1, -1);
    n_cmp++;
    if (BUF_COUNT !== CW'(DEPTH) || OVERFLOW !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_status: count=%0d ovf=%0b, want %0d 1", BUF_COUNT, OVERFLOW, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (!ent_eq(dut_head(), ev_log[b + i])) begin
        n_bad++;
        $display("FAIL ovf_pop%0d: got %s want %s", i, ent_str(dut_head()),
                 ent_str(ev_log[b + i]));
      end
      BUF_RD = 1'b1;
      tick();
      BUF_RD = 1'b0;
    end
    n_cmp++;
    if (BUF_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_drained: valid=%0b ovf=%0b, want 0 1", BUF_VALID, OVERFLOW);
    end
    do_clear();
  endtask

  task automatic test_back_to_back();
    int b;
    b = ev_log.size();
    for (int i = 0; i < DEPTH; i++) run_event(30, 2, 1'b0, 1'b0, 1'b0, -1, -1);
    run_event(30, 2, 1'b1, 1'b0, 1'b0, -1, -1);
    n_cmp++;
    if (BUF_COUNT !== CW'(DEPTH) || OVERFLOW !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_status: count=%0d ovf=%0b, want %0d 0", BUF_COUNT, OVERFLOW, DEPTH);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      n_cmp++;
      if (!ent_eq(dut_head(), ev_log[b + i])) begin
        n_bad++;
        $display("FAIL b2b_pop%0d: got %s want %s", i, ent_str(dut_head()),
                 ent_str(ev_log[b + i]));
      end
      BUF_RD = 1'b1;
      tick();
      BUF_RD = 1'b0;
    end
    n_cmp++;
    if (BUF_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_empty: valid=%0b, want 0", BUF_VALID);
    end
  endtask

  task automatic test_clr_capture();
    for (int i = 0; i < 2; i++) run_event(30, 2, 1'b0, 1'b0, 1'b0, -1, -1);
    run_event(10, 2, 1'b0, 1'b1, 1'b0, -1, -1);
    n_cmp++;
    if (BUF_COUNT !== '0 || BUF_VALID !== 1'b0 || OVERFLOW !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_status: count=%0d valid=%0b ovf=%0b, want 0 0 0",
               BUF_COUNT, BUF_VALID, OVERFLOW);
    end
    run_event(30, 2, 1'b0, 1'b0, 1'b0, -1, -1);
    n_cmp++;
    if (BUF_COUNT !== CW'(1) || !ent_eq(dut_head(), ev_log[ev_log.size() - 1])) begin
      n_bad++;
      $display("FAIL clr_next: count=%0d got %s want %s", BUF_COUNT, ent_str(dut_head()),
               ent_str(ev_log[ev_log.size() - 1]));
    end
    do_clear();
  endtask

  task automatic test_reset_mid();
    for (int o = 0; o < 11; o++) begin
      TRIGGERED = 1'b1;
      INTEGRAL  = IW'($urandom);
      BASELINE  = BW'($urandom);
      tick();
    end
    RESET     = 1'b1;
    TRIGGERED = 1'b0;
    tick();
    RESET = 1'b0;
    repeat (100) tick();
    n_cmp++;
    if (BUF_COUNT !== '0 || BUF_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_discard: count=%0d valid=%0b, want 0 0", BUF_COUNT, BUF_VALID);
    end
    run_event(30, 2, 1'b0, 1'b0, 1'b0, -1, -1);
    n_cmp++;
`ifdef SHWR_AREA_BUF_TIMESTAMP_EN
    if (BUF_TIME !== 32'd100) begin
      n_bad++;
      $display("FAIL rstmid_time: got %0d want 100", BUF_TIME);
    end
`else
    if (BUF_TIME !== 32'd0) begin
      n_bad++;
      $display("FAIL rstmid_time: got %0d want 0", BUF_TIME);
    end
`endif
    n_cmp++;
    if (BUF_COUNT !== CW'(1) || !ent_eq(dut_head(), mq[0])) begin
      n_bad++;
      $display("FAIL rstmid_entry: count=%0d got %s want %s", BUF_COUNT,
               ent_str(dut_head()), ent_str(mq[0]));
    end
    do_clear();
  endtask

  task automatic test_random();
    int len;
    for (int i = 0; i < 24; i++) begin
      len = $urandom_range(1, 45);
      if (len == T + 1) len = T + 2;
      run_event(len, $urandom_range(1, 6), 1'b0, 1'b0, 1'b1, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_short();
    test_overflow();
    test_back_to_back();
    test_clr_capture();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
